serial_adder: RTL and testbench

- Parametrised, multi-cycle successor to the combinational half/full adder cells.
- Adds two WIDTH-bit operands plus carry-in, processing DIGIT bits per clock, LSB first. One DIGIT-wide full-adder slice and a registered carry are reused every cycle.
- Used where area matters more than latency. The start/busy/done handshake lets a controller sequence it alongside other arithmetic units.

---
 rtl/serial_adder.sv | 130 +++++++++++++
 tb/tb_serial_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder. Adds two WIDTH-bit operands plus a
// carry-in DIGIT bits per clock, LSB first, reusing one DIGIT-wide full-adder
// slice and a registered carry. A start/busy/done handshake frames each add.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Number of add cycles per operation and the counter width to hold 0..N-1.
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_sh_reg;
    logic             carry_reg;
    logic [CW-1:0]    count_reg;
    logic             ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] sum_sh_next;

    // The shared DIGIT-wide slice: low digits of both operands plus the carry flop.
    always_comb begin
        {slice_cout, slice_sum} = {1'b0, a_reg[DIGIT-1:0]}
                                + {1'b0, b_reg[DIGIT-1:0]}
                                + {{DIGIT{1'b0}}, carry_reg};
        // Carry into the slice MSB recovered from sum bit = a ^ b ^ carry_in.
        slice_cmsb  = slice_sum[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];
        // New digit enters the sum register from the MSB end.
        sum_sh_next = (sum_sh_reg >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
    end

    // Control FSM with datapath shift registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            sum_sh_reg <= '0;
            carry_reg  <= 1'b0;
            count_reg  <= '0;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        carry_reg  <= cin;
                        sum_sh_reg <= '0;
                        count_reg  <= '0;
                        state_reg  <= RUN;
                        ready_reg  <= 1'b0;
                        busy_reg   <= 1'b1;
                    end
                end
                RUN: begin
                    a_reg      <= a_reg >> DIGIT;
                    b_reg      <= b_reg >> DIGIT;
                    carry_reg  <= slice_cout;
                    sum_sh_reg <= sum_sh_next;
                    if (count_reg == LAST) begin
                        state_reg <= DONE;
                        count_reg <= '0;
                        sum_reg   <= sum_sh_next;
                        cout_reg  <= slice_cout;
                        ovf_reg   <= slice_cmsb ^ slice_cout;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign sum   = sum_reg;
    assign cout  = cout_reg;
    assign ovf   = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomised checks of serial_adder across
// several WIDTH/DIGIT configurations against a plain-arithmetic reference.
module tb_serial_adder;

    localparam int NDUT  = 4;
    localparam int W_CFG [NDUT] = '{8, 8, 16, 16};
    localparam int D_CFG [NDUT] = '{1, 4, 2, 4};
    localparam int SWEEP = 300;

    logic        clk;
    logic        rst;
    logic        start_in [NDUT];
    logic [15:0] a_in     [NDUT];
    logic [15:0] b_in     [NDUT];
    logic        cin_in   [NDUT];
    logic        ready_o  [NDUT];
    logic        busy_o   [NDUT];
    logic        done_o   [NDUT];
    logic        cout_o   [NDUT];
    logic        ovf_o    [NDUT];
    logic [15:0] sum_o    [NDUT];

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int W = W_CFG[gi];
        logic [W-1:0] s;
        serial_adder #(.WIDTH(W), .DIGIT(D_CFG[gi])) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_in[gi]),
            .a     (a_in[gi][W-1:0]),
            .b     (b_in[gi][W-1:0]),
            .cin   (cin_in[gi]),
            .ready (ready_o[gi]),
            .busy  (busy_o[gi]),
            .done  (done_o[gi]),
            .sum   (s),
            .cout  (cout_o[gi]),
            .ovf   (ovf_o[gi])
        );
        assign sum_o[gi] = 16'(s);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int n_of(input int i);
        return W_CFG[i] / D_CFG[i];
    endfunction

    function automatic logic [15:0] mask_of(input int i);
        return (W_CFG[i] == 16) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic logic [15:0] rnd(input int i);
        return 16'($urandom) & mask_of(i);
    endfunction

    // Reference: integer sum modulo 2^W, carry is bit W, overflow by sign rule.
    task automatic model(input int i, input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         output logic [15:0] s, output logic co, output logic ov);
        int w;
        logic [16:0] full;
        w    = W_CFG[i];
        full = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
        s    = full[15:0] & mask_of(i);
        co   = full[w];
        ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    endtask

    // One add on DUT i; optionally re-pulses start with new operands mid-run.
    task automatic run_add(input int i, input logic [15:0] av, input logic [15:0] bv,
                           input logic cv, input bit perturb);
        int n, busy_cnt, done_cnt, done_at;
        logic [15:0] es, got_s;
        logic ec, eo, got_c, got_o;
        n = n_of(i);
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        got_s = '0; got_c = 1'b0; got_o = 1'b0;
        model(i, av, bv, cv, es, ec, eo);
        @(negedge clk);
        a_in[i] = av; b_in[i] = bv; cin_in[i] = cv; start_in[i] = 1'b1;
        @(negedge clk);
        start_in[i] = 1'b0;
        a_in[i] = rnd(i); b_in[i] = rnd(i); cin_in[i] = 1'($urandom_range(0, 1));
        for (int c = 0; c <= n + 2; c++) begin
            if (c > 0) @(negedge clk);
            if (busy_o[i]) busy_cnt++;
            if (done_o[i]) begin
                done_cnt++;
                done_at = c;
                got_s = sum_o[i]; got_c = cout_o[i]; got_o = ovf_o[i];
            end
            if (perturb && c == 2) begin
                start_in[i] = 1'b1; a_in[i] = rnd(i); b_in[i] = rnd(i); cin_in[i] = ~cv;
            end
            if (perturb && c == 3) start_in[i] = 1'b0;
        end
        start_in[i] = 1'b0;
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_latency", 32'(done_at), 32'(n));
        check("busy_cycles", 32'(busy_cnt), 32'(n));
        check("sum", 32'(got_s), 32'(es));
        check("cout", 32'(got_c), 32'(ec));
        check("ovf", 32'(got_o), 32'(eo));
        check("sum_held", 32'(sum_o[i]), 32'(es));
        check("ready_after", 32'(ready_o[i]), 32'd1);
        $display("add dut%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d (exp %h %0d %0d)",
                 i, av, bv, cv, got_s, got_c, got_o, es, ec, eo);
    endtask

    initial begin
        int next_acc [NDUT];
        int pend_due [NDUT];
        int last_done[NDUT];
        logic [15:0] pa [NDUT];
        logic [15:0] pb [NDUT];
        logic        pc [NDUT];
        logic [15:0] es;
        logic ec, eo;
        int dcnt;

        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            start_in[i] = 1'b0; a_in[i] = '0; b_in[i] = '0; cin_in[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check("rst_ready", 32'(ready_o[i]), 32'd1);
            check("rst_busy", 32'(busy_o[i]), 32'd0);
            check("rst_done", 32'(done_o[i]), 32'd0);
            check("rst_sum", 32'(sum_o[i]), 32'd0);
            check("rst_cout", 32'(cout_o[i]), 32'd0);
            check("rst_ovf", 32'(ovf_o[i]), 32'd0);
        end

        run_add(0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        run_add(0, 16'h007F, 16'h0001, 1'b0, 1'b0);
        run_add(0, 16'h0080, 16'h0080, 1'b1, 1'b0);
        run_add(1, 16'h003C, 16'h00A5, 1'b1, 1'b0);
        run_add(0, 16'h005A, 16'h0033, 1'b0, 1'b1);

        // Abort in the middle of a run: no done, outputs back to reset values.
        @(negedge clk);
        a_in[0] = 16'h00C3; b_in[0] = 16'h0055; cin_in[0] = 1'b1; start_in[0] = 1'b1;
        @(negedge clk);
        start_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(ready_o[0]), 32'd1);
        check("abort_busy", 32'(busy_o[0]), 32'd0);
        check("abort_sum", 32'(sum_o[0]), 32'd0);
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_o[0]) dcnt++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        $display("abort dut0 mid-run: ready=%0d busy=%0d sum=%h", ready_o[0], busy_o[0], sum_o[0]);
        run_add(0, 16'h0012, 16'h0034, 1'b0, 1'b0);

        // rst and start together: reset wins.
        @(negedge clk);
        rst = 1'b1; start_in[0] = 1'b1; a_in[0] = 16'h0011; b_in[0] = 16'h0022;
        @(negedge clk);
        rst = 1'b0; start_in[0] = 1'b0;
        check("rst_start_busy", 32'(busy_o[0]), 32'd0);
        check("rst_start_ready", 32'(ready_o[0]), 32'd1);
        @(negedge clk);
        check("rst_start_idle", 32'(busy_o[0]), 32'd0);
        $display("rst+start dut0: busy=%0d ready=%0d", busy_o[0], ready_o[0]);

        // Randomised sweep, start held high on every configuration.
        for (int i = 0; i < NDUT; i++) begin
            next_acc[i] = 0; pend_due[i] = -1; last_done[i] = -1;
            pa[i] = '0; pb[i] = '0; pc[i] = 1'b0;
        end
        for (int e = 0; e < SWEEP; e++) begin
            for (int i = 0; i < NDUT; i++) begin
                start_in[i] = 1'b1;
                a_in[i] = rnd(i); b_in[i] = rnd(i); cin_in[i] = 1'($urandom_range(0, 1));
                if (e == next_acc[i]) begin
                    pa[i] = a_in[i]; pb[i] = b_in[i]; pc[i] = cin_in[i];
                    pend_due[i] = e + n_of(i);
                    next_acc[i] = e + n_of(i) + 2;
                end
            end
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                check("sweep_done", 32'(done_o[i]), 32'(e == pend_due[i]));
                if (done_o[i] && e == pend_due[i]) begin
                    model(i, pa[i], pb[i], pc[i], es, ec, eo);
                    check("sweep_sum", 32'(sum_o[i]), 32'(es));
                    check("sweep_cout", 32'(cout_o[i]), 32'(ec));
                    check("sweep_ovf", 32'(ovf_o[i]), 32'(eo));
                    if (last_done[i] >= 0)
                        check("sweep_gap", 32'(e - last_done[i]), 32'(n_of(i) + 2));
                    last_done[i] = e;
                    $display("sweep dut%0d W=%0d D=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d",
                             i, W_CFG[i], D_CFG[i], pa[i], pb[i], pc[i], sum_o[i], cout_o[i], ovf_o[i]);
                end
            end
        end
        for (int i = 0; i < NDUT; i++) start_in[i] = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
